// File: rtl/sdc_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdc_arb_pkg
// Shared definitions for the two-master Wishbone arbiter: arbiter state
// encoding, master count and Wishbone field widths.
// -----------------------------------------------------------------------------
package sdc_arb_pkg;

    localparam int NUM_MASTERS = 2;

    localparam int ADR_W  = 32;
    localparam int DAT_W  = 32;
    localparam int SEL_W  = 4;
    localparam int CTI_W  = 3;
    localparam int BTE_W  = 2;
    localparam int WDOG_W = 16;

    // state  | meaning
    // IDLE   | no owner, slave side parked at zero
    // OWN0   | master 0 owns the slave
    // OWN1   | master 1 owns the slave
    // ABORT  | watchdog fired, waiting for the aborted master to drop cyc
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdc_arb_watchdog.sv
// -----------------------------------------------------------------------------
// sdc_arb_watchdog
// Ack-wait counter for the arbiter. Counts cycles while count_en is high,
// clears on clear, and flags expired when the count reaches TIMEOUT_CYCLES.
// Only instantiated when SDC_ARB_TIMEOUT_EN is defined.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   count_en : owner is strobing and the slave has not responded
//   clear    : slave responded or the arbiter changes state
//   expired  : count equals TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module sdc_arb_watchdog
    import sdc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    logic [WDOG_W-1:0] count_q;

    assign expired = (count_q == WDOG_W'(TIMEOUT_CYCLES));

    // Saturate at the limit so a stalled clear can never wrap past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/sdc_wb_arbiter.sv
// -----------------------------------------------------------------------------
// sdc_wb_arbiter
// Two-master to one-slave Wishbone arbiter. A granted master keeps the slave
// for as long as it holds cyc (bursts are never split); ties from idle are
// resolved round-robin. The slave side is a combinational copy of the owner.
//
// Optional feature: define SDC_ARB_TIMEOUT_EN to build the ack-wait watchdog.
// When it expires the owner gets a one-cycle err, the slave strobe is dropped
// and the arbiter parks in ABORT until that master releases cyc.
//
// Ports
//   wb_clk_i, wb_rst_i         : clock, asynchronous active-high reset
//   m0_* / m1_* inputs          : master request (adr, dat, sel, we, cyc, stb,
//                                 cti, bte)
//   m0_* / m1_* outputs         : read data, ack, err back to each master
//   s_* outputs                 : shared slave request
//   s_dat_i, s_ack_i, s_err_i   : slave response
//   grant_o                     : one-hot owner, bit0 = m0, 00 when no owner
// -----------------------------------------------------------------------------
module sdc_wb_arbiter
    import sdc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,

    input  logic [ADR_W-1:0]       m0_adr_i,
    input  logic [DAT_W-1:0]       m0_dat_i,
    input  logic [SEL_W-1:0]       m0_sel_i,
    input  logic                   m0_we_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic [CTI_W-1:0]       m0_cti_i,
    input  logic [BTE_W-1:0]       m0_bte_i,
    output logic [DAT_W-1:0]       m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic [ADR_W-1:0]       m1_adr_i,
    input  logic [DAT_W-1:0]       m1_dat_i,
    input  logic [SEL_W-1:0]       m1_sel_i,
    input  logic                   m1_we_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic [CTI_W-1:0]       m1_cti_i,
    input  logic [BTE_W-1:0]       m1_bte_i,
    output logic [DAT_W-1:0]       m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic [ADR_W-1:0]       s_adr_o,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic [SEL_W-1:0]       s_sel_o,
    output logic                   s_we_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic [CTI_W-1:0]       s_cti_o,
    output logic [BTE_W-1:0]       s_bte_o,
    input  logic [DAT_W-1:0]       s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,

    output logic [NUM_MASTERS-1:0] grant_o
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;   // 0 = m0 won the last tie, 1 = m1
    logic       owning;
    logic       timeout_hit;

    assign owning = (state_q == OWN0) || (state_q == OWN1);

`ifdef SDC_ARB_TIMEOUT_EN
    logic abort_owner_q;                      // master that was aborted, 1 = m1
    logic owner_stb;
    logic wd_count_en;
    logic wd_clear;
    logic wd_expired;

    assign owner_stb   = (state_q == OWN0) ? m0_stb_i :
                         (state_q == OWN1) ? m1_stb_i : 1'b0;
    assign wd_count_en = owner_stb && !s_ack_i && !s_err_i;
    assign wd_clear    = s_ack_i || s_err_i || (state_d != state_q);
    assign timeout_hit = owning && wd_expired;

    sdc_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .count_en (wd_count_en),
        .clear    (wd_clear),
        .expired  (wd_expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            abort_owner_q <= 1'b0;
        end else if (timeout_hit) begin
            abort_owner_q <= (state_q == OWN1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_grant_q) begin
                        state_d      = OWN0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = OWN1;
                        last_grant_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (timeout_hit) begin
                    state_d = ABORT;
                end else if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (timeout_hit) begin
                    state_d = ABORT;
                end else if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            ABORT: begin
`ifdef SDC_ARB_TIMEOUT_EN
                if (abort_owner_q ? !m1_cyc_i : !m0_cyc_i) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data fans out to both masters; only ack/err qualify it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = {state_q == OWN1, state_q == OWN0};

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_cti_o  = '0;
        s_bte_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i && !timeout_hit;
                s_stb_o  = m0_stb_i && !timeout_hit;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                m0_ack_o = s_ack_i && !timeout_hit;
                m0_err_o = s_err_i || timeout_hit;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i && !timeout_hit;
                s_stb_o  = m1_stb_i && !timeout_hit;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                m1_ack_o = s_ack_i && !timeout_hit;
                m1_err_o = s_err_i || timeout_hit;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sdc_wb_arbiter.sv
module tb_sdc_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [2:0]  m0_cti_i, m1_cti_i;
    logic [1:0]  m0_bte_i, m1_bte_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  grant_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // term encoding: {m1_err, m1_ack, m0_err, m0_ack}
    typedef struct {
        logic [3:0]  term;
        logic [31:0] dat;
        logic        chk_dat;
        logic [1:0]  grant;
        int          id;
    } exp_t;

    exp_t sb[$];

    sdc_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i),
        .m0_we_i  (m0_we_i),  .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i),
        .m0_cti_i (m0_cti_i), .m0_bte_i (m0_bte_i), .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i),
        .m1_we_i  (m1_we_i),  .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i),
        .m1_cti_i (m1_cti_i), .m1_bte_i (m1_bte_i), .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),
        .s_cti_o  (s_cti_o),  .s_bte_o  (s_bte_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),
        .grant_o  (grant_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic push(input logic [3:0] term, input logic [31:0] dat, input logic chk_dat,
                        input logic [1:0] gnt, input int id);
        exp_t e;
        e.term = term; e.dat = dat; e.chk_dat = chk_dat; e.grant = gnt; e.id = id;
        sb.push_back(e);
    endtask

    // Monitor: every termination the DUT presents must match the next expected one.
    initial begin
        exp_t        e;
        logic [3:0]  term;
        logic [31:0] rdat;
        forever begin
            @(negedge clk);
            term = {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};
            if (term != 4'b0000) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_term actual=%b required=none grant=%b", term, grant_o);
                end else begin
                    e    = sb.pop_front();
                    rdat = (term[1] || term[3]) ? m1_dat_o : m0_dat_o;
                    if (term !== e.term || grant_o !== e.grant || (e.chk_dat && rdat !== e.dat))
                        $display("FAIL sb_term_%0d actual term=%b grant=%b dat=%h required term=%b grant=%b dat=%h",
                                 e.id, term, grant_o, rdat, e.term, e.grant, e.dat);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit expired");
    end

    logic [1:0] rr_exp [4];

    initial begin
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m0_cti_i = '0; m0_bte_i = '0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        m1_cti_i = '0; m1_bte_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_grant", grant_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 1'b0);
        check("rst_s_stb", s_stb_o, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Single owner: m0 read, slave acks two cycles after grant
        m0_adr_i = 32'h1000_0028; m0_sel_i = 4'hF; m0_we_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        check("t1_s_cyc_before_grant", s_cyc_o, 1'b0);
        tick();
        @(negedge clk);
        check("t1_s_cyc_latency", s_cyc_o, 1'b1);
        check("t1_grant", grant_o, 2'b01);
        check("t1_s_adr", s_adr_o, 32'h1000_0028);
        check("t1_s_sel", s_sel_o, 4'hF);
        tick();
        tick();
        s_ack_i = 1; s_dat_i = 32'hCAFE_0028;
        push(4'b0001, 32'hCAFE_0028, 1'b1, 2'b01, 1);
        @(negedge clk);
        check("t1_m1_ack_low", m1_ack_o, 1'b0);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        @(negedge clk);
        check("t1_grant_released", grant_o, 2'b00);
        tick();

        // Round robin: both masters raise cyc together from idle
        for (int i = 0; i < 4; i++) begin
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
            tick();
            s_ack_i = 1; s_dat_i = 32'hA000_0000 + i;
            push((rr_exp[i] == 2'b01) ? 4'b0001 : 4'b0100, 32'hA000_0000 + i, 1'b1, rr_exp[i], 10 + i);
            @(negedge clk);
            check($sformatf("t2_rr_grant_%0d", i), grant_o, rr_exp[i]);
            tick();
            s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
            tick();
        end

        // Burst: m1 holds the slave for 8 beats while m0 waits
        m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = 3'b010; m1_adr_i = 32'h2000_0000;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0000;
        for (int b = 0; b < 8; b++) begin
            m1_cti_i = (b == 7) ? 3'b111 : 3'b010;
            m1_adr_i = 32'h2000_0000 + 32'(b * 4);
            s_ack_i  = 1; s_dat_i = 32'hB000_0000 + b;
            push(4'b0100, 32'hB000_0000 + b, 1'b1, 2'b10, 20 + b);
            @(negedge clk);
            check($sformatf("t3_burst_grant_%0d", b), grant_o, 2'b10);
            check($sformatf("t3_burst_cti_%0d", b), s_cti_o, (b == 7) ? 3'b111 : 3'b010);
            tick();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_cti_i = 3'b000;
        @(negedge clk);
        check("t3_release_cycle_grant", grant_o, 2'b10);
        tick();
        s_ack_i = 1; s_dat_i = 32'hD00D_0030;
        push(4'b0001, 32'hD00D_0030, 1'b1, 2'b01, 30);
        @(negedge clk);
        check("t3_handoff_grant", grant_o, 2'b01);
        check("t3_handoff_s_cyc", s_cyc_o, 1'b1);
        check("t3_handoff_s_adr", s_adr_o, 32'h3000_0000);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        tick();

`ifdef SDC_ARB_TIMEOUT_EN
        // Timeout: slave never answers, limit of 4 cycles
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h4000_0000;
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t4_stb_cycle_%0d", c), s_stb_o, 1'b1);
            tick();
        end
        push(4'b0010, 32'h0, 1'b0, 2'b01, 40);
        @(negedge clk);
        check("t4_stb_at_timeout", s_stb_o, 1'b0);
        check("t4_cyc_at_timeout", s_cyc_o, 1'b0);
        tick();
        m1_cyc_i = 1; m1_stb_i = 1;
        @(negedge clk);
        check("t4_abort_grant", grant_o, 2'b00);
        check("t4_abort_s_cyc", s_cyc_o, 1'b0);
        tick();
        @(negedge clk);
        check("t4_abort_holds", grant_o, 2'b00);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        @(negedge clk);
        check("t4_idle_after_abort", grant_o, 2'b00);
        tick();
        @(negedge clk);
        check("t4_m1_granted", grant_o, 2'b10);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        tick();
`endif

        // Reset mid transfer: tie goes to m0, then reset, then tie again
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        m0_adr_i = 32'h5000_0000;
        tick();
        @(negedge clk);
        check("t5_grant_before_reset", grant_o, 2'b01);
        #2;
        rst = 1'b1; s_ack_i = 1;
        #1;
        check("t5_async_s_cyc", s_cyc_o, 1'b0);
        check("t5_async_s_stb", s_stb_o, 1'b0);
        check("t5_async_s_adr", s_adr_o, 32'h0);
        check("t5_async_grant", grant_o, 2'b00);
        check("t5_async_m0_ack", m0_ack_o, 1'b0);
        tick();
        tick();
        s_ack_i = 0; rst = 1'b0;
        tick();
        @(negedge clk);
        check("t5_tie_after_reset", grant_o, 2'b01);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        tick();

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sdc_wb_arbiter.md
SDC_WB_ARBITER -- requirements
Module: sdc_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the slave ack-wait limit in clock cycles (range 1..65535).
REQ-002 Port wb_clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 Port wb_rst_i, input, 1 bit: reset; asynchronous, active-high.
REQ-004 Ports m0_adr_i / m1_adr_i, input, 32 bits: master address.
REQ-005 Ports m0_dat_i / m1_dat_i, input, 32 bits: master write data.
REQ-006 Ports m0_sel_i / m1_sel_i, input, 4 bits: byte selects.
REQ-007 Ports m0_we_i, m0_cyc_i, m0_stb_i and m1_we_i, m1_cyc_i, m1_stb_i, input, 1 bit each: Wishbone control.
REQ-008 Ports m0_cti_i / m1_cti_i, input, 3 bits, and m0_bte_i / m1_bte_i, input, 2 bits: burst tags.
REQ-009 Ports m0_dat_o / m1_dat_o, output, 32 bits: read data.
REQ-010 Ports m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, output, 1 bit each: termination.
REQ-011 Ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o, output: the shared slave side, with widths matching the master inputs.
REQ-012 Ports s_dat_i, input, 32 bits; s_ack_i and s_err_i, input, 1 bit each: slave response.
REQ-013 Port grant_o, output, 2 bits: one-hot current owner (bit0 = m0); 00 when no master owns the slave.

Function
REQ-014 The block shall implement a state machine with states IDLE, OWN0, OWN1 and ABORT.
REQ-015 In IDLE the block shall stay in IDLE while m0_cyc_i and m1_cyc_i are both 0.
REQ-016 In IDLE with exactly one cyc high, the block shall enter the matching OWN state on the next edge.
REQ-017 In IDLE with both cyc high, the block shall grant the master not recorded in last_grant and then update last_grant to the granted master.
REQ-018 Grant latency from cyc assertion to s_cyc_o shall be exactly 1 cycle.
REQ-019 In OWNx the block shall remain in OWNx while mx_cyc_i is 1; bursts and back-to-back cycles shall not be interrupted.
REQ-020 In OWNx with mx_cyc_i = 0, the block shall go to the other OWN state if the other master's cyc is 1, otherwise to IDLE.
REQ-021 In OWNx, s_adr/dat/sel/we/cti/bte/cyc/stb shall be combinational copies of master x's inputs.
REQ-022 In IDLE and ABORT, all s_* outputs shall be 0.
REQ-023 s_dat_i shall drive both m0_dat_o and m1_dat_o.
REQ-024 s_ack_i and s_err_i shall be routed only to the owner; the non-owner's ack and err shall be 0.
REQ-025 When s_ack_i or s_err_i arrives with no owner, the block shall discard it.
REQ-026 The block shall support simultaneous release by the owner and request by the other master with zero idle cycles.

Reset
REQ-027 On wb_rst_i = 1, the block shall immediately force state to IDLE, last_grant to m1 (so m0 wins the first tie), the watchdog counter to 0, grant_o to 00, and all m*_ack/err and s_cyc/stb/we to 0.
REQ-028 A reset asserted mid-transfer shall abort the transfer without any ack.

Configuration
REQ-029 With SDC_ARB_TIMEOUT_EN defined, a 16-bit counter shall count cycles in OWNx while s_stb_o = 1 and s_ack_i = s_err_i = 0.
REQ-030 The counter shall clear on any ack/err and on every state change.
REQ-031 When the counter equals TIMEOUT_CYCLES, the block shall assert mx_err_o for one cycle, force s_cyc_o and s_stb_o to 0 in that same cycle, and enter ABORT.
REQ-032 ABORT shall exit to IDLE when the aborted master drops cyc.
REQ-033 Without SDC_ARB_TIMEOUT_EN, the counter and ABORT shall not be built and a grant shall wait indefinitely.

Structure
REQ-034 The shared package sdc_arb_pkg shall hold the state enum, NUM_MASTERS = 2, and the Wishbone width constants (ADR_W = 32, DAT_W = 32, SEL_W = 4).
REQ-035 The watchdog shall be the sub-module sdc_arb_watchdog, instantiated only under SDC_ARB_TIMEOUT_EN.

Verification
REQ-036 Single-owner check: after reset, m0 single read at 0x1000_0028 with slave ack after 2 cycles -> s_cyc_o high 1 cycle after m0_cyc_i, m0_ack_o once, m1_ack_o stays 0, grant_o = 01.
REQ-037 Round-robin check: both cyc raised in the same cycle, repeated 4 times -> grant order m0, m1, m0, m1.
REQ-038 Burst check: m1 8-beat burst (cti 010, then 111) while m0 requests -> m0 waits; grant_o switches to 01 on the edge after m1 drops cyc, with no idle cycle.
REQ-039 Timeout check (TIMEOUT_CYCLES = 4, macro on): slave never acks -> m0_err_o pulses in cycle 4; s_stb_o = 0 in that same cycle; state is ABORT until m0 drops cyc.
REQ-040 Reset check: wb_rst_i asserted in the middle of the m0 transfer -> all s_* outputs and grant_o are 0 asynchronously; the next tie after reset is granted to m0.
